// File: rtl/mac_table_aging.sv
`default_nettype none
// ============================================================================
// mac_table_aging
// Learning MAC table with ageing sweep, bulk flush, live entry count and
// RD_CH parallel lookup channels.
// Revision: 1.0
// ============================================================================
module mac_table_aging #(
    parameter  int PORT_NUM = 4,
    parameter  int ADDR_W   = 8,
    parameter  int RD_CH    = 4,
    parameter  int AGE_W    = 9,
    parameter  int AGE_INIT = 300,
    parameter  int TICK_DIV = 32768,
    localparam int PW       = $clog2(PORT_NUM)
) (
    input  logic                    iclk,
    input  logic                    i_rst,
    input  logic                    i_learn_valid,
    input  logic [ADDR_W-1:0]       i_learn_addr,
    input  logic [PW-1:0]           i_learn_port,
    input  logic [RD_CH-1:0]        i_lookup_valid,
    input  logic [RD_CH*ADDR_W-1:0] i_lookup_addr,
    input  logic                    i_flush,
    output logic [RD_CH-1:0]        o_lookup_valid,
    output logic [RD_CH-1:0]        o_lookup_hit,
    output logic [RD_CH*PW-1:0]     o_lookup_port,
    output logic [ADDR_W:0]         o_entry_count,
    output logic                    o_flushing
);

    localparam int               c_depth   = 2**ADDR_W;
    localparam int               c_tw      = $clog2(TICK_DIV);
    localparam logic [ADDR_W-1:0] c_last   = ADDR_W'(c_depth - 1);
    localparam logic [AGE_W-1:0] c_age_one = AGE_W'(1);
    localparam logic [ADDR_W:0]  c_cnt_one = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_idx, w_idx_nxt;
    logic                r_pend, w_pend_nxt;
    logic [c_tw-1:0]     r_tick;
    logic [ADDR_W:0]     r_count, w_count_nxt;

    logic                r_valid [c_depth];
    logic [PW-1:0]       r_port  [c_depth];
    logic [AGE_W-1:0]    r_age   [c_depth];

    logic                w_tick, w_sweep_act, w_flush_act, w_cnt_clear;
    logic                w_learn_ok, w_new, w_expire;

    logic [RD_CH-1:0]    r_lk_valid, r_lk_hit, w_lk_hit;
    logic [RD_CH*PW-1:0] r_lk_port, w_lk_port;

    assign w_tick = (r_tick == c_tw'(TICK_DIV - 1));

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            r_tick <= '0;
        end else begin
            r_tick <= w_tick ? '0 : r_tick + c_tw'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pend_nxt  = r_pend;
        w_sweep_act = 1'b0;
        w_flush_act = 1'b0;
        w_cnt_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_flush) begin
                    // A tick losing to a flush is remembered, not dropped
                    w_state_nxt = ST_FLUSH;
                    w_idx_nxt   = '0;
                    w_pend_nxt  = r_pend | w_tick;
                end else if (w_tick || r_pend) begin
                    w_state_nxt = ST_SWEEP;
                    w_idx_nxt   = '0;
                    w_pend_nxt  = 1'b0;
                end
            end
            ST_SWEEP: begin
                w_pend_nxt = r_pend | w_tick;
                if (i_flush) begin
                    w_state_nxt = ST_FLUSH;
                    w_idx_nxt   = '0;
                end else begin
                    w_sweep_act = 1'b1;
                    w_idx_nxt   = r_idx + ADDR_W'(1);
                    if (r_idx == c_last) w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                w_pend_nxt  = r_pend | w_tick;
                w_flush_act = 1'b1;
                w_idx_nxt   = r_idx + ADDR_W'(1);
                if (r_idx == c_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clear = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_pend  <= w_pend_nxt;
            r_count <= w_count_nxt;
        end
    end

    // A learn on the entry under the sweep pointer wins over its ageing step
    assign w_learn_ok = i_learn_valid && (r_state != ST_FLUSH);
    assign w_new      = w_learn_ok && !r_valid[i_learn_addr];
    assign w_expire   = w_sweep_act && r_valid[r_idx] && (r_age[r_idx] == c_age_one)
                        && !(w_learn_ok && (i_learn_addr == r_idx));

    always_comb begin
        w_count_nxt = r_count;
        if (w_cnt_clear) begin
            w_count_nxt = '0;
        end else if (w_new && !w_expire) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (w_expire && !w_new) begin
            w_count_nxt = r_count - c_cnt_one;
        end
    end

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_valid[i] <= 1'b0;
                r_port[i]  <= '0;
                r_age[i]   <= '0;
            end
        end else begin
            if (w_flush_act) begin
                r_valid[r_idx] <= 1'b0;
                r_age[r_idx]   <= '0;
            end else if (w_sweep_act && r_valid[r_idx]) begin
                if (r_age[r_idx] == c_age_one) begin
                    r_valid[r_idx] <= 1'b0;
                    r_age[r_idx]   <= '0;
                end else begin
                    r_age[r_idx] <= r_age[r_idx] - c_age_one;
                end
            end
            if (w_learn_ok) begin
                r_valid[i_learn_addr] <= 1'b1;
                r_port[i_learn_addr]  <= i_learn_port;
                r_age[i_learn_addr]   <= AGE_W'(AGE_INIT);
            end
        end
    end

    // Entries at or below the flush pointer are treated as already gone
    for (genvar c = 0; c < RD_CH; c++) begin : g_lookup
        logic [ADDR_W-1:0] w_addr;
        assign w_addr      = i_lookup_addr[c*ADDR_W +: ADDR_W];
        assign w_lk_hit[c] = i_lookup_valid[c] && r_valid[w_addr]
                             && !((r_state == ST_FLUSH) && (w_addr <= r_idx));
        assign w_lk_port[c*PW +: PW] = w_lk_hit[c] ? r_port[w_addr] : '0;
    end

    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            r_lk_valid <= '0;
            r_lk_hit   <= '0;
            r_lk_port  <= '0;
        end else begin
            r_lk_valid <= i_lookup_valid;
            r_lk_hit   <= w_lk_hit;
            r_lk_port  <= w_lk_port;
        end
    end

    assign o_lookup_valid = r_lk_valid;
    assign o_lookup_hit   = r_lk_hit;
    assign o_lookup_port  = r_lk_port;
    assign o_entry_count  = r_count;
    assign o_flushing     = (r_state == ST_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_mac_table_aging.sv
`default_nettype none
// ============================================================================
// tb_mac_table_aging
// Directed scoreboard bench: PORT_NUM=4, ADDR_W=4, RD_CH=2, AGE_INIT=3, TICK_DIV=32.
// Revision: 1.0
// ============================================================================
module tb_mac_table_aging;

    logic       iclk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_learn_valid = 1'b0;
    logic [3:0] i_learn_addr = '0;
    logic [1:0] i_learn_port = '0;
    logic [1:0] i_lookup_valid = '0;
    logic [7:0] i_lookup_addr = '0;
    logic       i_flush = 1'b0;
    logic [1:0] o_lookup_valid;
    logic [1:0] o_lookup_hit;
    logic [3:0] o_lookup_port;
    logic [4:0] o_entry_count;
    logic       o_flushing;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [2:0] q0 [$];
    logic [2:0] q1 [$];
    logic [2:0] m_act, m_exp;

    mac_table_aging #(
        .PORT_NUM(4), .ADDR_W(4), .RD_CH(2), .AGE_W(9), .AGE_INIT(3), .TICK_DIV(32)
    ) dut (
        .iclk(iclk), .i_rst(i_rst),
        .i_learn_valid(i_learn_valid), .i_learn_addr(i_learn_addr), .i_learn_port(i_learn_port),
        .i_lookup_valid(i_lookup_valid), .i_lookup_addr(i_lookup_addr), .i_flush(i_flush),
        .o_lookup_valid(o_lookup_valid), .o_lookup_hit(o_lookup_hit), .o_lookup_port(o_lookup_port),
        .o_entry_count(o_entry_count), .o_flushing(o_flushing)
    );

    always #5 iclk = ~iclk;

    // cyc == k after the k-th rising edge following reset release
    always @(posedge iclk or posedge i_rst) begin
        if (i_rst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge iclk);
        #1;
        i_learn_valid  = 1'b0;
        i_lookup_valid = '0;
        i_flush        = 1'b0;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) cycle();
    endtask

    task automatic learn(input int addr, input int port);
        i_learn_valid = 1'b1;
        i_learn_addr  = addr[3:0];
        i_learn_port  = port[1:0];
    endtask

    task automatic lk_set(input int ch, input int addr, input int hit, input int port);
        i_lookup_valid[ch]        = 1'b1;
        i_lookup_addr[ch*4 +: 4]  = addr[3:0];
        if (ch == 0) q0.push_back({hit[0], port[1:0]});
        else         q1.push_back({hit[0], port[1:0]});
    endtask

    // Scoreboard monitor: pops an expectation whenever a channel presents a result
    always @(negedge iclk) begin
        for (int c = 0; c < 2; c++) begin
            if (o_lookup_valid[c]) begin
                m_act = {o_lookup_hit[c], o_lookup_port[c*2 +: 2]};
                if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL lookup_unexpected ch%0d: got hit/port=%b expected none", c, m_act);
                end else begin
                    if (c == 0) m_exp = q0.pop_front();
                    else        m_exp = q1.pop_front();
                    chk($sformatf("lookup_ch%0d_hit_port", c), int'(m_act), int'(m_exp));
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge iclk);
        #1;
        chk("reset_lookup_valid", int'(o_lookup_valid), 0);
        chk("reset_lookup_hit", int'(o_lookup_hit), 0);
        chk("reset_lookup_port", int'(o_lookup_port), 0);
        chk("reset_count", int'(o_entry_count), 0);
        chk("reset_flushing", int'(o_flushing), 0);
        @(posedge iclk);
        #1;
        i_rst = 1'b0;

        // Basic learn / hit / miss
        learn(5, 2); cycle();
        lk_set(0, 5, 1, 2); lk_set(1, 6, 0, 0); cycle();
        chk("count_first_learn", int'(o_entry_count), 1);
        // Same-cycle relearn returns old contents
        learn(5, 1); lk_set(0, 5, 1, 2); cycle();
        lk_set(0, 5, 1, 1); cycle();
        chk("count_relearn", int'(o_entry_count), 1);
        learn(3, 3); cycle();
        learn(7, 0); cycle();
        chk("count_three", int'(o_entry_count), 3);

        // Ageing of entry 3: ticks at edges 32, 64, 96; entry i swept at tick+1+i
        goto_cyc(50); lk_set(0, 3, 1, 3); cycle();
        goto_cyc(82); lk_set(0, 3, 1, 3); cycle();
        goto_cyc(99);
        chk("count_before_expiry", int'(o_entry_count), 3);
        lk_set(0, 3, 1, 3); cycle();
        chk("count_after_expiry3", int'(o_entry_count), 2);
        lk_set(0, 3, 0, 0); cycle();
        goto_cyc(102);
        chk("count_after_expiry5", int'(o_entry_count), 1);

        // Learn entry 7 in the cycle its age-1 sweep happens
        goto_cyc(103); learn(7, 1); cycle();
        chk("count_learn_at_sweep", int'(o_entry_count), 1);
        lk_set(0, 7, 1, 1); lk_set(1, 3, 0, 0); cycle();
        goto_cyc(170); lk_set(0, 7, 1, 1); cycle();
        goto_cyc(200);
        chk("count_entry7_expired", int'(o_entry_count), 0);
        lk_set(0, 7, 0, 0); cycle();

        // Fill 10 entries, flush mid-sweep (sweep of tick 224 at index 7)
        goto_cyc(202);
        for (int i = 0; i < 10; i++) begin
            learn(i, i % 4);
            cycle();
        end
        chk("count_fill", int'(o_entry_count), 10);
        goto_cyc(231);
        for (int k = 231; k <= 248; k++) begin
            chk("flushing_window", int'(o_flushing), (k >= 232 && k <= 247) ? 1 : 0);
            if (k == 231) i_flush = 1'b1;
            if (k == 233) begin lk_set(0, 1, 0, 0); lk_set(1, 9, 1, 1); end
            if (k == 240) chk("count_during_flush", int'(o_entry_count), 10);
            if (k == 248) begin
                chk("count_after_flush", int'(o_entry_count), 0);
                lk_set(0, 0, 0, 0); lk_set(1, 9, 0, 0);
            end
            cycle();
        end

        // Flush from IDLE covering tick 256: pending sweep follows immediately
        i_flush = 1'b1; cycle();
        chk("flushing_b_start", int'(o_flushing), 1);
        goto_cyc(265);
        chk("flushing_b_last", int'(o_flushing), 1);
        cycle();
        chk("flushing_b_done", int'(o_flushing), 0);
        learn(2, 3); cycle();
        chk("count_after_learn2", int'(o_entry_count), 1);
        goto_cyc(322); lk_set(0, 2, 1, 3); cycle();
        chk("count_pending_sweep_expiry", int'(o_entry_count), 0);
        lk_set(0, 2, 0, 0); cycle();

        // Reset in the middle of a flush
        goto_cyc(325); learn(10, 2); cycle();
        learn(11, 3); cycle();
        chk("count_two", int'(o_entry_count), 2);
        goto_cyc(330); i_flush = 1'b1; cycle();
        goto_cyc(334); lk_set(0, 10, 1, 2); lk_set(1, 2, 0, 0); cycle();
        chk("flushing_c", int'(o_flushing), 1);
        chk("count_kept_in_flush", int'(o_entry_count), 2);
        @(negedge iclk);
        #1;
        i_rst = 1'b1;
        #1;
        chk("midflush_reset_valid", int'(o_lookup_valid), 0);
        chk("midflush_reset_hit", int'(o_lookup_hit), 0);
        chk("midflush_reset_port", int'(o_lookup_port), 0);
        chk("midflush_reset_count", int'(o_entry_count), 0);
        chk("midflush_reset_flushing", int'(o_flushing), 0);
        repeat (2) @(posedge iclk);
        #1;
        i_rst = 1'b0;
        learn(4, 3); cycle();
        lk_set(0, 4, 1, 3); lk_set(1, 10, 0, 0); cycle();
        chk("count_after_reset_learn", int'(o_entry_count), 1);
        repeat (3) cycle();
        chk("scoreboard_drained_ch0", q0.size(), 0);
        chk("scoreboard_drained_ch1", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
